// File: rtl/seq_game_ctrl.sv
// Button-sequence game controller: records a pattern, plays it back on the LED,
// captures the player's repeat and scores it, all paced by one step timer.
module seq_game_ctrl #(
    parameter int STEPS    = 8,
    parameter int TICK_DIV = 50_000_000
) (
    input  logic                         CLK,
    input  logic                         RST_N,
    input  logic                         START,
    input  logic                         CLR,
    input  logic                         BTN,
    output logic                         LD,
    output logic [STEPS-1:0]             STEP_OH,
    output logic [STEPS-1:0]             PATTERN,
    output logic                         BUSY,
    output logic                         PASS,
    output logic                         FAIL,
    output logic [$clog2(STEPS+1)-1:0]   ERRORS,
    output logic [2:0]                   STATE_DBG
);

    localparam int TW = $clog2(TICK_DIV);
    localparam int SW = $clog2(STEPS);
    localparam int EW = $clog2(STEPS+1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_RECORD = 3'd1,
        S_PLAY   = 3'd2,
        S_ENTER  = 3'd3,
        S_CHECK  = 3'd4,
        S_RESULT = 3'd5
    } state_t;

    state_t            state_q;
    logic [TW-1:0]     timer_q;
    logic [SW-1:0]     step_q;
    logic [STEPS-1:0]  pattern_q;
    logic [STEPS-1:0]  entry_q;
    logic [EW-1:0]     errors_q;
    logic [EW-1:0]     errors_d;
    logic              pass_q;
    logic              fail_q;

    logic tick;
    logic last_step;
    logic stepping;

    assign tick      = (timer_q == TW'(TICK_DIV-1));
    assign last_step = (step_q == SW'(STEPS-1));
    assign stepping  = (state_q == S_RECORD) || (state_q == S_PLAY) || (state_q == S_ENTER);

    always_comb begin
        errors_d = '0;
        for (int i = 0; i < STEPS; i++) begin
            errors_d = errors_d + EW'(pattern_q[i] ^ entry_q[i]);
        end
    end

    // Each stepping phase runs STEPS ticks; the tick on the last step hands over
    // to the next phase with timer and step already back at zero.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q   <= S_IDLE;
            timer_q   <= '0;
            step_q    <= '0;
            pattern_q <= '0;
            entry_q   <= '0;
            errors_q  <= '0;
            pass_q    <= 1'b0;
            fail_q    <= 1'b0;
        end else if (CLR) begin
            state_q  <= S_IDLE;
            timer_q  <= '0;
            step_q   <= '0;
            errors_q <= '0;
            pass_q   <= 1'b0;
            fail_q   <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE, S_RESULT: begin
                    if (START) begin
                        state_q   <= S_RECORD;
                        timer_q   <= '0;
                        step_q    <= '0;
                        pattern_q <= '0;
                        entry_q   <= '0;
                        errors_q  <= '0;
                        pass_q    <= 1'b0;
                        fail_q    <= 1'b0;
                    end
                end
                S_RECORD, S_PLAY, S_ENTER: begin
                    if (tick) begin
                        if (state_q == S_RECORD) pattern_q[step_q] <= BTN;
                        if (state_q == S_ENTER)  entry_q[step_q]   <= BTN;
                        timer_q <= '0;
                        if (last_step) begin
                            step_q <= '0;
                            case (state_q)
                                S_RECORD: state_q <= S_PLAY;
                                S_PLAY:   state_q <= S_ENTER;
                                default:  state_q <= S_CHECK;
                            endcase
                        end else begin
                            step_q <= step_q + SW'(1);
                        end
                    end else begin
                        timer_q <= timer_q + TW'(1);
                    end
                end
                S_CHECK: begin
                    errors_q <= errors_d;
                    pass_q   <= (pattern_q == entry_q);
                    fail_q   <= (pattern_q != entry_q);
                    state_q  <= S_RESULT;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign LD        = (state_q == S_PLAY) && pattern_q[step_q];
    assign STEP_OH   = stepping ? (STEPS'(1) << step_q) : '0;
    assign PATTERN   = pattern_q;
    assign BUSY      = stepping || (state_q == S_CHECK);
    assign PASS      = pass_q;
    assign FAIL      = fail_q;
    assign ERRORS    = errors_q;
    assign STATE_DBG = state_q;

endmodule

// File: tb/tb_seq_game_ctrl.sv
// Bench for seq_game_ctrl: directed game sequence with randomized between-tick
// button noise, checked against a phase/step model derived from elapsed cycles.
module tb_seq_game_ctrl;

    localparam int STEPS    = 8;
    localparam int TICK_DIV = 4;
    localparam int PH       = STEPS * TICK_DIV;
    localparam int EW       = $clog2(STEPS+1);
    localparam int W        = STEPS + 2 + EW;

    // clock / reset
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic             start = 1'b0;
    logic             clr   = 1'b0;
    logic             btn   = 1'b0;
    logic             ld;
    logic [STEPS-1:0] step_oh;
    logic [STEPS-1:0] pattern;
    logic             busy;
    logic             pass;
    logic             fail;
    logic [EW-1:0]    errors;
    logic [2:0]       state_dbg;

    int n_checks = 0;
    int n_errors = 0;
    logic [W-1:0] exp_q[$];

    seq_game_ctrl #(.STEPS(STEPS), .TICK_DIV(TICK_DIV)) dut (
        .CLK(clk), .RST_N(rst_n), .START(start), .CLR(clr), .BTN(btn),
        .LD(ld), .STEP_OH(step_oh), .PATTERN(pattern), .BUSY(busy),
        .PASS(pass), .FAIL(fail), .ERRORS(errors), .STATE_DBG(state_dbg)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // scoreboard model: final result is just the comparison of two bit vectors
    function automatic logic [W-1:0] model_result(input logic [STEPS-1:0] pat,
                                                  input logic [STEPS-1:0] ent);
        logic [EW-1:0] e;
        e = EW'($countones(pat ^ ent));
        return {pat, (pat == ent), (pat != ent), e};
    endfunction

    task automatic check_quiet(input string tag);
        check({tag, "_busy"},    busy,    0);
        check({tag, "_step_oh"}, step_oh, 0);
        check({tag, "_ld"},      ld,      0);
        check({tag, "_pass"},    pass,    0);
        check({tag, "_fail"},    fail,    0);
        check({tag, "_errors"},  errors,  0);
    endtask

    // driver: one game from START; stop_kind 1 = CLR+START at cycle stop_c,
    // stop_kind 2 = async reset at cycle stop_c
    task automatic run_game(input logic [STEPS-1:0] pat, input logic [STEPS-1:0] ent,
                            input bit glitch, input bit noise,
                            input int stop_c, input int stop_kind);
        logic [W-1:0]     exp;
        logic [STEPS-1:0] tgt;
        logic [STEPS-1:0] one;
        int ph;
        int st;
        one = 1;
        if (stop_kind == 0) exp_q.push_back(model_result(pat, ent));
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int c = 0; c < 3*PH; c++) begin
            ph = c / PH;
            st = (c % PH) / TICK_DIV;
            if (stop_kind == 1 && c == stop_c) begin
                clr = 1'b1; start = 1'b1;
                @(negedge clk);
                clr = 1'b0; start = 1'b0;
                check_quiet("clr");
                check("clr_pattern", pattern, pat);
                @(negedge clk);
                check("clr_idle_busy", busy, 0);
                return;
            end
            if (stop_kind == 2 && c == stop_c) begin
                rst_n = 1'b0;
                #1;
                check_quiet("async_rst");
                check("async_rst_pattern", pattern, 0);
                @(negedge clk);
                rst_n = 1'b1;
                @(negedge clk);
                check("post_rst_busy", busy, 0);
                check("post_rst_step_oh", step_oh, 0);
                return;
            end
            check("busy", busy, 1);
            check("step_oh", step_oh, one << st);
            check("ld", ld, (ph == 1) ? pat[st] : 1'b0);
            if (c == 0) begin
                check("start_pattern_clr", pattern, 0);
                check("start_pass_clr", pass, 0);
                check("start_fail_clr", fail, 0);
                check("start_errors_clr", errors, 0);
            end
            if (c == PH) check("record_exit_pattern", pattern, pat);
            tgt = (ph == 2) ? ent : pat;
            if (c % TICK_DIV == TICK_DIV-1)
                btn = (ph == 1) ? 1'($urandom_range(0, 1)) : tgt[st];
            else
                btn = glitch ? 1'b1 : 1'($urandom_range(0, 1));
            start = (noise && (c == 5 || c == 2*PH + 9)) ? 1'b1 : 1'b0;
            @(negedge clk);
        end
        start = 1'b0;
        check("check_busy", busy, 1);
        check("check_step_oh", step_oh, 0);
        check("check_ld", ld, 0);
        @(negedge clk);
        exp = exp_q.pop_front();
        check("result_pattern", pattern, exp[W-1 -: STEPS]);
        check("result_pass", pass, exp[EW+1]);
        check("result_fail", fail, exp[EW]);
        check("result_errors", errors, exp[EW-1:0]);
        check("result_busy", busy, 0);
        @(negedge clk);
        check("result_hold_pass", pass, exp[EW+1]);
        check("result_hold_errors", errors, exp[EW-1:0]);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check_quiet("reset");
        check("reset_pattern", pattern, 0);
        rst_n = 1'b1;
        @(negedge clk);
        check_quiet("idle");

        run_game(8'hA5, 8'hA5, 1'b0, 1'b0, -1, 0);
        run_game(8'hA5, 8'h5A, 1'b0, 1'b0, -1, 0);
        run_game(8'hA5, 8'hA4, 1'b0, 1'b0, -1, 0);
        run_game(8'(($urandom)), 8'(($urandom)), 1'b0, 1'b1, -1, 0);
        run_game(8'hA5, 8'h3C, 1'b0, 1'b1, -1, 0);
        run_game(8'hA5, 8'hFF, 1'b0, 1'b0, 2*PH + 13, 1);
        run_game(8'h00, 8'(($urandom)), 1'b1, 1'b0, -1, 0);
        run_game(8'hA5, 8'h00, 1'b0, 1'b0, PH + 13, 2);
        for (int g = 0; g < 3; g++) begin
            run_game(8'(($urandom)), 8'(($urandom)), 1'b0, 1'b1, -1, 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/seq_game_ctrl.md
Name: seq_game_ctrl

Overview:
- Controller for the 8-step button-sequence game.
- Sequences four phases on a common step timer:
  - records a button pattern one bit per step,
  - plays it back on the LED,
  - captures the player's repeat entry,
  - compares the two and reports pass/fail with a mismatch count.
- Sits between the debounced button and the board LEDs / 7-seg result logic.

Parameters:
- STEPS, 8, number of pattern steps (2..16).
- TICK_DIV, 50_000_000, CLK cycles per step slot (≥2; benches use 4).

Ports:
- CLK  input  1  system clock, rising edge.
- RST_N  input  1  asynchronous, active-low reset.
- START  input  1  single-cycle pulse (already synchronised/debounced); begins a new game.
- CLR  input  1  synchronous abort to IDLE.
- BTN  input  1  debounced player button level.
- LD  output  1  playback LED.
- STEP_OH  output  STEPS  one-hot current step, zero when not in a stepping phase.
- PATTERN  output  STEPS  recorded pattern, bit i = step i.
- BUSY  output  1  high in RECORD, PLAY, ENTER, CHECK.
- PASS  output  1  entry matched pattern.
- FAIL  output  1  entry mismatched.
- ERRORS  output  $clog2(STEPS+1)  count of mismatched steps.

Behaviour:
- Reset (RST_N low, async): state=IDLE; timer=0; step=0; PATTERN=0; entry=0; ERRORS=0; LD=0; STEP_OH=0; BUSY=0; PASS=0; FAIL=0.
- Step timer:
  - counts 0..TICK_DIV-1, cleared on every state entry;
  - tick = (timer==TICK_DIV-1), one cycle wide;
  - step increments on tick and is cleared on state entry.
- States: IDLE, RECORD, PLAY, ENTER, CHECK, RESULT.
- IDLE:
  - outputs quiescent;
  - START → RECORD on the next edge, clearing PATTERN, entry, ERRORS, PASS and FAIL.
- RECORD:
  - on each tick, PATTERN[step] <= BTN, sampled in the tick cycle;
  - the tick at step==STEPS-1 → PLAY;
  - duration exactly STEPS*TICK_DIV cycles.
- PLAY:
  - LD = PATTERN[step] (combinational from registers);
  - the tick at step==STEPS-1 → ENTER.
- ENTER:
  - on each tick, entry[step] <= BTN;
  - the tick at the last step → CHECK.
- CHECK (1 cycle):
  - ERRORS <= popcount(PATTERN ^ entry);
  - PASS <= (PATTERN==entry); FAIL <= the inverse;
  - → RESULT.
- RESULT:
  - PASS/FAIL/ERRORS/PATTERN held;
  - START → RECORD (same clearing as from IDLE).
- STEP_OH = 1<<step in RECORD/PLAY/ENTER, else 0. LD=0 outside PLAY.
- BUSY=1 in RECORD/PLAY/ENTER/CHECK.
- START while BUSY is ignored; no queuing.
- CLR from any state → IDLE next edge:
  - clears timer, step, PASS, FAIL and ERRORS;
  - PATTERN is retained.
- CLR and START in the same cycle: CLR wins.
- BTN changes between ticks have no effect; only the tick-cycle value is sampled.
- Latency, START to PASS/FAIL valid: 1 + 3*STEPS*TICK_DIV + 1 cycles.
  - With STEPS=8, TICK_DIV=4: 98 cycles after the START cycle.
- step never exceeds STEPS-1; no wrap occurs inside a phase.

Test Plan:
- Reset mid-game:
  - Stimulus: assert RST_N low during PLAY.
  - Required: all outputs 0 immediately (asynchronous, before the next edge); state IDLE after release.
- Matching entry (STEPS=8, TICK_DIV=4):
  - Stimulus: START; BTN drives 1,0,1,0,0,1,0,1 at the RECORD ticks.
  - Required: PATTERN=8'hA5 at RECORD exit.
  - Required: LD shows 1,0,1,0,0,1,0,1 for 4 cycles each during PLAY.
  - Stimulus: same entry.
  - Required: PASS=1, FAIL=0, ERRORS=0, 98 cycles after START.
- Mismatched entry:
  - Stimulus: pattern 8'hA5 recorded, entry 8'h5A.
  - Required: FAIL=1, PASS=0, ERRORS=8.
  - Stimulus: entry 8'hA4 instead.
  - Required: ERRORS=1.
- START ignored while busy:
  - Stimulus: START pulses during RECORD and during ENTER.
  - Required: no restart; timing unchanged; BUSY stays 1 until RESULT.
- CLR handling:
  - Stimulus: CLR and START together in ENTER.
  - Required: IDLE next cycle; BUSY=0, STEP_OH=0; PATTERN still 8'hA5.
  - Stimulus: a later START.
  - Required: PATTERN cleared to 0 on entry to RECORD.
- BTN glitches between ticks:
  - Stimulus: BTN pulses high only on non-tick cycles throughout RECORD.
  - Required: PATTERN=8'h00.
